// File: rtl/led_pwm_wb8.sv
// led_pwm_wb8: 8-bit Wishbone responder driving eight PWM-dimmed LEDs.
// Register map: 0x0 EN mask, 0x1 PRE prescaler, 0x2..0x9 DUTY0..DUTY7,
// 0xA..0xF unmapped (writes dropped, reads return 0x00).
// Build macro LED_PWM_WB8_SHADOW_EN: when defined, each LED compares against
// a shadow copy of its duty that reloads only at the PWM wrap event, so every
// PWM period is glitch-free. When undefined, the duty registers feed the
// comparators directly.
module led_pwm_wb8 (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    input  logic [3:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    output logic       O_wb_ack,
    output logic [7:0] O_wb_dat,
    output logic [7:0] O_led
);

    localparam logic [3:0] ADR_EN       = 4'h0;
    localparam logic [3:0] ADR_PRE      = 4'h1;
    localparam logic [3:0] ADR_DUTY_LO  = 4'h2;
    localparam logic [3:0] ADR_DUTY_HI  = 4'h9;

    // Programmable registers
    logic [7:0] en_q;
    logic [7:0] pre_q;
    logic [7:0] duty_q [8];

    // Bus response registers
    logic       ack_q;
    logic [7:0] rdat_q;
    logic [7:0] rdat_d;

    // PWM engine state
    logic [7:0] preCnt_q;
    logic [7:0] preCnt_d;
    logic [7:0] pwmCnt_q;
    logic [7:0] pwmCnt_d;
    logic [7:0] led_q;
    logic [7:0] led_d;
    logic       tick;

    // Duty values the comparators actually use
    logic [7:0] dutyAct [8];

    // Address decode helpers
    logic       wrEn;
    logic       rdEn;
    logic       dutyHit;
    logic [2:0] dutyIdx;

    // Decode the bus request; DUTYn index is the address minus two, and the
    // low three bits of that difference are enough for addresses 2..9.
    always_comb begin
        wrEn    = I_wb_stb & I_wb_we;
        rdEn    = I_wb_stb & ~I_wb_we;
        dutyHit = (I_wb_adr >= ADR_DUTY_LO) && (I_wb_adr <= ADR_DUTY_HI);
        dutyIdx = I_wb_adr[2:0] - 3'd2;
    end

    // Register file: a held write simply rewrites the same value each cycle.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            en_q  <= 8'h00;
            pre_q <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                duty_q[i] <= 8'h00;
            end
        end else if (wrEn) begin
            if (I_wb_adr == ADR_EN) begin
                en_q <= I_wb_dat;
            end else if (I_wb_adr == ADR_PRE) begin
                pre_q <= I_wb_dat;
            end else if (dutyHit) begin
                duty_q[dutyIdx] <= I_wb_dat;
            end
        end
    end

    // Read mux: DUTYn returns the pending (written) value, unmapped reads 0.
    always_comb begin
        rdat_d = rdat_q;
        if (rdEn) begin
            if (I_wb_adr == ADR_EN) begin
                rdat_d = en_q;
            end else if (I_wb_adr == ADR_PRE) begin
                rdat_d = pre_q;
            end else if (dutyHit) begin
                rdat_d = duty_q[dutyIdx];
            end else begin
                rdat_d = 8'h00;
            end
        end
    end

    // Ack is the strobe delayed by one clock; read data lands with it.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            ack_q  <= 1'b0;
            rdat_q <= 8'h00;
        end else begin
            ack_q  <= I_wb_stb;
            rdat_q <= rdat_d;
        end
    end

    // Prescaler and PWM counter next state; >= lets a lowered PRE take
    // effect immediately instead of waiting for the counter to overflow.
    always_comb begin
        tick     = (preCnt_q >= pre_q);
        preCnt_d = tick ? 8'h00 : preCnt_q + 8'd1;
        pwmCnt_d = tick ? pwmCnt_q + 8'd1 : pwmCnt_q;
    end

    // Prescaler and PWM counter registers.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            preCnt_q <= 8'h00;
            pwmCnt_q <= 8'h00;
        end else begin
            preCnt_q <= preCnt_d;
            pwmCnt_q <= pwmCnt_d;
        end
    end

`ifdef LED_PWM_WB8_SHADOW_EN
    logic [7:0] dutyAct_q [8];
    logic       wrap;

    // Wrap event: the tick that takes pwmCnt from 255 back to 0.
    always_comb begin
        wrap = tick && (pwmCnt_q == 8'hFF);
    end

    // Shadow duties reload at the wrap; a DUTYn write on the same edge is
    // not yet visible here, so it applies from the following wrap.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            for (int i = 0; i < 8; i++) begin
                dutyAct_q[i] <= 8'h00;
            end
        end else if (wrap) begin
            for (int i = 0; i < 8; i++) begin
                dutyAct_q[i] <= duty_q[i];
            end
        end
    end

    // Comparators use the shadow copies.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dutyAct[i] = dutyAct_q[i];
        end
    end
`else
    // Comparators use the written duties directly.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dutyAct[i] = duty_q[i];
        end
    end
`endif

    // LED compare: duty 0 is always off, duty 255 is off one tick in 256.
    always_comb begin
        led_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            led_d[i] = en_q[i] & (pwmCnt_q < dutyAct[i]);
        end
    end

    // Registered LED outputs, lagging pwmCnt by one clock.
    always_ff @(posedge I_wb_clk or posedge I_reset) begin
        if (I_reset) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign O_wb_ack = ack_q;
    assign O_wb_dat = rdat_q;
    assign O_led    = led_q;

endmodule

// File: tb/tb_led_pwm_wb8.sv
// tb_led_pwm_wb8: directed self-checking bench for led_pwm_wb8.
// Covers reset state, bus readback, duty ratio, duty extremes, prescaler
// period and the shadow/no-shadow duty update behaviour.
module tb_led_pwm_wb8;

    logic       clock = 1'b0;
    logic       reset;
    logic       stb;
    logic       we;
    logic [3:0] adr;
    logic [7:0] wdat;
    logic       ack;
    logic [7:0] rdat;
    logic [7:0] led;

    int testCount = 0;
    int failCount = 0;

    led_pwm_wb8 dut (
        .I_wb_clk (clock),
        .I_reset  (reset),
        .I_wb_stb (stb),
        .I_wb_we  (we),
        .I_wb_adr (adr),
        .I_wb_dat (wdat),
        .O_wb_ack (ack),
        .O_wb_dat (rdat),
        .O_led    (led)
    );

    // 100 MHz-style clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive the bus inputs.
    task automatic applyStimulus(input logic s, input logic w,
                                 input logic [3:0] a, input logic [7:0] d);
        stb  = s;
        we   = w;
        adr  = a;
        wdat = d;
    endtask

    // Single-cycle write, called and returning at a falling edge.
    task automatic wbWrite(input logic [3:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        @(negedge clock);
        checkOutput($sformatf("wrAck%0h", a), {15'd0, ack}, 16'd1);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    // Single-cycle read with ack, data and data-hold checks.
    task automatic wbRead(input logic [3:0] a, input logic [7:0] expData);
        applyStimulus(1'b1, 1'b0, a, 8'h00);
        @(negedge clock);
        checkOutput($sformatf("rdAck%0h", a), {15'd0, ack}, 16'd1);
        checkOutput($sformatf("rdDat%0h", a), {8'd0, rdat}, {8'd0, expData});
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clock);
        checkOutput($sformatf("ackDrop%0h", a), {15'd0, ack}, 16'd0);
        checkOutput($sformatf("datHold%0h", a), {8'd0, rdat}, {8'd0, expData});
    endtask

    // Wait (bounded) for a low-to-high transition of one LED.
    task automatic findRise(input int bitIdx, input int budget, output logic found);
        logic prev;
        logic cur;
        found = 1'b0;
        prev  = led[bitIdx];
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            cur = led[bitIdx];
            if (!prev && cur) begin
                found = 1'b1;
                break;
            end
            prev = cur;
        end
    endtask

    // From a rising edge: length of the high run and distance to next rise.
    task automatic measurePeriod(input int bitIdx, output int period, output int runLen);
        logic prev;
        logic cur;
        logic inRun;
        logic done;
        prev   = 1'b1;
        inRun  = 1'b1;
        done   = 1'b0;
        runLen = 1;
        period = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clock);
            period++;
            cur = led[bitIdx];
            if (cur && !prev) begin
                done = 1'b1;
                break;
            end
            if (inRun && cur) runLen++;
            else inRun = 1'b0;
            prev = cur;
        end
        if (!done) period = 0;
    endtask

    // From a high sample: count consecutive high samples (bounded).
    task automatic runLength(input int bitIdx, output int len);
        len = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clock);
            if (led[bitIdx]) len++;
            else break;
        end
    endtask

    // Count high samples of one LED over a window of clocks.
    task automatic countHigh(input int bitIdx, input int len, output int highs);
        highs = 0;
        for (int n = 0; n < len; n++) begin
            @(negedge clock);
            if (led[bitIdx]) highs++;
        end
    endtask

    initial begin
        logic found;
        int   period;
        int   runLen;
        int   highs;
        logic inRun;

        // ---------------- reset state ----------------
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rstLed", {8'd0, led}, 16'h0000);
        checkOutput("rstAck", {15'd0, ack}, 16'd0);
        checkOutput("rstDat", {8'd0, rdat}, 16'h0000);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("postRstLed", {8'd0, led}, 16'h0000);
        for (int a = 0; a < 16; a++) begin
            wbRead(4'(a), 8'h00);
        end

        // ---------------- reset aborts a transaction ----------------
        applyStimulus(1'b1, 1'b1, 4'h0, 8'h55);
        #2 reset = 1'b1;
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("abortAck", {15'd0, ack}, 16'd0);
        wbRead(4'h0, 8'h00);

        // ---------------- readback ----------------
        wbWrite(4'h0, 8'hA5);
        wbWrite(4'h1, 8'h03);
        wbWrite(4'h5, 8'h40);
        wbWrite(4'hC, 8'h77);
        wbRead(4'h0, 8'hA5);
        wbRead(4'h1, 8'h03);
        wbRead(4'h5, 8'h40);
        wbRead(4'hC, 8'h00);

        // ---------------- duty ratio: 64 of 256 ----------------
        wbWrite(4'h1, 8'h00);
        wbWrite(4'h0, 8'h01);
        wbWrite(4'h2, 8'h40);
        repeat (600) @(negedge clock);
        findRise(0, 300, found);
        checkOutput("ratioRise", {15'd0, found}, 16'd1);
        measurePeriod(0, period, runLen);
        checkOutput("ratioPeriod", 16'(period), 16'd256);
        checkOutput("ratioHigh", 16'(runLen), 16'd64);

        // ---------------- duty extremes ----------------
        wbWrite(4'h0, 8'hFF);
        wbWrite(4'h3, 8'h00);
        wbWrite(4'h4, 8'hFF);
        repeat (600) @(negedge clock);
        countHigh(1, 256, highs);
        checkOutput("duty0High", 16'(highs), 16'd0);
        countHigh(2, 256, highs);
        checkOutput("duty255High", 16'(highs), 16'd255);

        // EN acts on the next LED update, not at the wrap
        wbWrite(4'h0, 8'h00);
        @(negedge clock);
        checkOutput("enOffNow", {8'd0, led}, 16'h0000);

        // ---------------- prescaler: PRE=2, duty 0x80 ----------------
        wbWrite(4'h1, 8'h02);
        wbWrite(4'h0, 8'h01);
        wbWrite(4'h2, 8'h80);
        repeat (1600) @(negedge clock);
        findRise(0, 1000, found);
        checkOutput("preRise", {15'd0, found}, 16'd1);
        measurePeriod(0, period, runLen);
        checkOutput("prePeriod", 16'(period), 16'd768);
        checkOutput("preHigh", 16'(runLen), 16'd384);

        // ---------------- duty change mid-period ----------------
        wbWrite(4'h2, 8'h10);
        wbWrite(4'h1, 8'h00);
        wbWrite(4'h0, 8'h01);
        repeat (600) @(negedge clock);
        findRise(0, 300, found);
        checkOutput("midRise1", {15'd0, found}, 16'd1);
        // This sample reflects pwm_cnt=0; seven more reach pwm_cnt=8.
        runLen = 1;
        inRun  = 1'b1;
        for (int n = 0; n < 7; n++) begin
            @(negedge clock);
            if (inRun && led[0]) runLen++;
            else inRun = 1'b0;
        end
        applyStimulus(1'b1, 1'b1, 4'h2, 8'hF0);
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
        if (inRun && led[0]) runLen++;
        else inRun = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!inRun) break;
            @(negedge clock);
            if (led[0]) runLen++;
            else inRun = 1'b0;
        end
`ifdef LED_PWM_WB8_SHADOW_EN
        checkOutput("midRunCur", 16'(runLen), 16'd16);
`else
        checkOutput("midRunCur", 16'(runLen), 16'd240);
`endif
        findRise(0, 300, found);
        checkOutput("midRise2", {15'd0, found}, 16'd1);
        runLength(0, runLen);
        checkOutput("midRunNext", 16'(runLen), 16'd240);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
